// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single mem_mapper-style memory port.
//
// Requests from m0 and m1 are granted round-robin and forwarded downstream. The ID of every
// accepted read is pushed into an in-order ID FIFO so read returns are steered back to the
// master that issued them, combinationally and with no added latency. A read is stalled while
// the ID FIFO is full; writes are never stalled by the FIFO.
//
// Optional feature (compile-time macro MEM_ARBITER_FIXED_PRIORITY_EN):
//   defined   - m0 always wins when both masters request; no round-robin pointer.
//   undefined - round-robin; after every accept the other master gets priority.
//
// Parameters:
//   MAX_OUTSTANDING - reads in flight / ID FIFO depth; power of two, 2..16.
//
// Ports:
//   clk, reset_n                   - clock (rising edge) and asynchronous active-low reset
//   mN_read_req / mN_write_req     - requester N read / write request, held until mN_ready
//   mN_addr / mN_write_data        - requester N byte address and write data
//   mN_byte_enable                 - requester N write byte lanes
//   mN_ready                       - requester N request accepted this cycle
//   mN_read_data(_valid)           - read data returned to requester N, one-cycle pulse
//   mem_ready                      - downstream can accept a request
//   mem_read_req / mem_write_req   - forwarded request of the granted master
//   mem_addr / mem_write_data / mem_byte_enable - forwarded from the granted master
//   mem_read_data(_valid)          - downstream read return, in order, one per accepted read

module mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_byte_enable,
    input  logic        m0_write_req,
    input  logic        m0_read_req,
    output logic [31:0] m0_read_data,
    output logic        m0_read_data_valid,

    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_byte_enable,
    input  logic        m1_write_req,
    input  logic        m1_read_req,
    output logic [31:0] m1_read_data,
    output logic        m1_read_data_valid,

    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_write_req,
    output logic        mem_read_req,
    input  logic [31:0] mem_read_data,
    input  logic        mem_read_data_valid
);

    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTSTANDING);

    logic                       req0;
    logic                       req1;
    logic                       gnt_valid;
    logic                       gnt_id;
    logic                       gnt_read;
    logic                       gnt_write;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       stall;
    logic                       push;
    logic                       pop;
    logic                       head_id;

    logic [MAX_OUTSTANDING-1:0] id_fifo_q;
    logic [MAX_OUTSTANDING-1:0] id_fifo_d;
    logic [PtrW-1:0]            wr_ptr_q;
    logic [PtrW-1:0]            wr_ptr_d;
    logic [PtrW-1:0]            rd_ptr_q;
    logic [PtrW-1:0]            rd_ptr_d;
    logic [CntW-1:0]            count_q;
    logic [CntW-1:0]            count_d;

    // Requests are masked while reset is asserted so nothing is granted or forwarded.
    assign req0 = reset_n & (m0_read_req | m0_write_req);
    assign req1 = reset_n & (m1_read_req | m1_write_req);
    assign gnt_valid = req0 | req1;

`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
    // m1 only wins when m0 is idle.
    assign gnt_id = ~req0 & req1;
`else
    logic rr_q;
    logic rr_d;

    // rr_q names the master that wins a tie; a lone requester always wins.
    assign gnt_id = (req0 & req1) ? rr_q : req1;
`endif

    assign gnt_read  = gnt_valid & (gnt_id ? m1_read_req  : m0_read_req);
    assign gnt_write = gnt_valid & (gnt_id ? m1_write_req : m0_write_req);

    // Full is taken from registered occupancy, so a coinciding pop does not release the stall.
    assign fifo_full  = (count_q == CntFull);
    assign fifo_empty = (count_q == '0);
    assign stall      = fifo_full & gnt_read;

    always_comb begin
        mem_read_req    = gnt_read & ~stall;
        mem_write_req   = gnt_write;
        mem_addr        = '0;
        mem_write_data  = '0;
        mem_byte_enable = '0;
        if (reset_n) begin
            // With no grant gnt_id is 0, so the data outputs follow m0.
            mem_addr        = gnt_id ? m1_addr        : m0_addr;
            mem_write_data  = gnt_id ? m1_write_data  : m0_write_data;
            mem_byte_enable = gnt_id ? m1_byte_enable : m0_byte_enable;
        end
    end

    assign m0_ready = mem_ready & gnt_valid & ~gnt_id & ~stall;
    assign m1_ready = mem_ready & gnt_valid &  gnt_id & ~stall;

    assign push = mem_ready & mem_read_req;
    // A return with nothing outstanding is dropped rather than underflowing the FIFO.
    assign pop  = mem_read_data_valid & ~fifo_empty;

    assign head_id = id_fifo_q[rd_ptr_q];

    always_comb begin
        m0_read_data_valid = pop & ~head_id;
        m1_read_data_valid = pop &  head_id;
        m0_read_data       = m0_read_data_valid ? mem_read_data : '0;
        m1_read_data       = m1_read_data_valid ? mem_read_data : '0;
    end

    // ID FIFO next state; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        id_fifo_d = id_fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            id_fifo_d[wr_ptr_q] = gnt_id;
            wr_ptr_d            = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_fifo_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            id_fifo_q <= id_fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
    // After any accept the other master gets priority on the next tie.
    always_comb begin
        rr_d = rr_q;
        if (mem_ready && (mem_read_req || mem_write_req)) begin
            rr_d = ~gnt_id;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned MAXO = 4;
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr, m1_addr, m0_write_data, m1_write_data;
    logic [3:0]  m0_byte_enable, m1_byte_enable;
    logic        m0_write_req, m1_write_req, m0_read_req, m1_read_req;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_read_data_valid, m1_read_data_valid;
    logic        mem_ready;
    logic [31:0] mem_addr, mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_write_req, mem_read_req;
    logic [31:0] mem_read_data;
    logic        mem_read_data_valid;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .m0_ready           (m0_ready),
        .m0_addr            (m0_addr),
        .m0_write_data      (m0_write_data),
        .m0_byte_enable     (m0_byte_enable),
        .m0_write_req       (m0_write_req),
        .m0_read_req        (m0_read_req),
        .m0_read_data       (m0_read_data),
        .m0_read_data_valid (m0_read_data_valid),
        .m1_ready           (m1_ready),
        .m1_addr            (m1_addr),
        .m1_write_data      (m1_write_data),
        .m1_byte_enable     (m1_byte_enable),
        .m1_write_req       (m1_write_req),
        .m1_read_req        (m1_read_req),
        .m1_read_data       (m1_read_data),
        .m1_read_data_valid (m1_read_data_valid),
        .mem_ready          (mem_ready),
        .mem_addr           (mem_addr),
        .mem_write_data     (mem_write_data),
        .mem_byte_enable    (mem_byte_enable),
        .mem_write_req      (mem_write_req),
        .mem_read_req       (mem_read_req),
        .mem_read_data      (mem_read_data),
        .mem_read_data_valid(mem_read_data_valid)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Outstanding reads are a queue of issuer IDs; prio is the master that wins a tie.
    int          mq[$];
    int          prio = 0;
    int          g;
    int          h;
    logic        g_rd, g_wr, blk, e_mrd, e_mwr, e_r0, e_r1, ret;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;

    always @(negedge clk) begin
        if (!reset_n) begin
            mq.delete();
            prio = 0;
            chk("rst_m0_ready", m0_ready, 0);
            chk("rst_m1_ready", m1_ready, 0);
            chk("rst_mem_read_req", mem_read_req, 0);
            chk("rst_mem_write_req", mem_write_req, 0);
            chk("rst_m0_valid", m0_read_data_valid, 0);
            chk("rst_m1_valid", m1_read_data_valid, 0);
        end else begin
            if ((m0_read_req | m0_write_req) && (m1_read_req | m1_write_req))
                g = FIXED ? 0 : prio;
            else if (m0_read_req | m0_write_req) g = 0;
            else if (m1_read_req | m1_write_req) g = 1;
            else g = -1;
            g_rd   = (g == 0) ? m0_read_req  : (g == 1) ? m1_read_req  : 1'b0;
            g_wr   = (g == 0) ? m0_write_req : (g == 1) ? m1_write_req : 1'b0;
            blk    = g_rd && (mq.size() == int'(MAXO));
            e_mrd  = g_rd && !blk;
            e_mwr  = g_wr;
            e_r0   = mem_ready && (g == 0) && !blk;
            e_r1   = mem_ready && (g == 1) && !blk;
            e_addr  = (g == 1) ? m1_addr : m0_addr;
            e_wdata = (g == 1) ? m1_write_data : m0_write_data;
            e_be    = (g == 1) ? m1_byte_enable : m0_byte_enable;
            ret    = mem_read_data_valid && (mq.size() > 0);
            h      = ret ? mq[0] : -1;

            chk("m0_ready", m0_ready, e_r0);
            chk("m1_ready", m1_ready, e_r1);
            chk("mem_read_req", mem_read_req, e_mrd);
            chk("mem_write_req", mem_write_req, e_mwr);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_write_data", mem_write_data, e_wdata);
            chk("mem_byte_enable", mem_byte_enable, e_be);
            chk("m0_read_data_valid", m0_read_data_valid, h == 0);
            chk("m1_read_data_valid", m1_read_data_valid, h == 1);
            if (h == 0) chk("m0_read_data", m0_read_data, mem_read_data);
            if (h == 1) chk("m1_read_data", m1_read_data, mem_read_data);

            // The next rising edge commits what is visible now.
            if (ret) void'(mq.pop_front());
            if (mem_ready && (e_mrd || e_mwr)) begin
                if (!FIXED) prio = 1 - g;
                if (e_mrd) mq.push_back(g);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read_req = 0; m0_write_req = 0; m1_read_req = 0; m1_write_req = 0;
        m0_addr = 0; m1_addr = 0; m0_write_data = 0; m1_write_data = 0;
        m0_byte_enable = 0; m1_byte_enable = 0;
        mem_ready = 1; mem_read_data_valid = 0; mem_read_data = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        #1;
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_read_req", mem_read_req, 0);
        chk("reset_m0_read_data", m0_read_data, 0);
        cyc();
        reset_n = 1;
    endtask

    logic [31:0] tag;
    int          who;
    localparam int N = 8;

    initial begin
        reset_n = 0;
        idle();
        cyc();
        do_reset();

        // 1: lone m0 read, data returns three cycles later.
        m0_read_req = 1; m0_addr = 32'h1000;
        #1;
        chk("t1_m0_ready", m0_ready, 1);
        chk("t1_mem_addr", mem_addr, 32'h1000);
        cyc();
        m0_read_req = 0;
        #1 chk("t1_m0_ready_drop", m0_ready, 0);
        cyc();
        cyc();
        mem_read_data_valid = 1; mem_read_data = 32'hDEADBEEF;
        #1;
        chk("t1_m0_valid", m0_read_data_valid, 1);
        chk("t1_m0_data", m0_read_data, 32'hDEADBEEF);
        chk("t1_m1_valid", m1_read_data_valid, 0);
        cyc();
        idle();

        // 2: both masters stream reads, returns two cycles behind.
        do_reset();
        for (int i = 0; i < N + 2; i++) begin
            m0_read_req = (i < N); m1_read_req = (i < N);
            m0_addr = 32'h100 + 32'(i); m1_addr = 32'h200 + 32'(i);
            if (i >= 2) begin
                mem_read_data_valid = 1;
                mem_read_data = 32'hA000_0000 + 32'(i - 2);
            end else begin
                mem_read_data_valid = 0;
            end
            #1;
            if (i < N) begin
                chk("t2_m0_ready", m0_ready, FIXED ? 1 : ((i % 2) == 0));
                chk("t2_m1_ready", m1_ready, FIXED ? 0 : ((i % 2) == 1));
            end
            if (i >= 2) begin
                who = FIXED ? 0 : ((i - 2) % 2);
                tag = 32'hA000_0000 + 32'(i - 2);
                if (who == 0) chk("t2_m0_ret", m0_read_data, tag);
                else chk("t2_m1_ret", m1_read_data, tag);
            end
            cyc();
        end
        idle();

        // 3: m1 fills the ID FIFO; fifth read held, write still forwarded.
        do_reset();
        m1_read_req = 1;
        for (int k = 0; k < 4; k++) begin
            m1_addr = 32'h2000 + 32'(4 * k);
            #1 chk("t3_m1_ready", m1_ready, 1);
            cyc();
        end
        m1_addr = 32'h2010;
        #1;
        chk("t3_full_m1_ready", m1_ready, 0);
        chk("t3_full_mem_read_req", mem_read_req, 0);
        cyc();
        m1_read_req = 0; m1_write_req = 1; m1_write_data = 32'h55; m1_byte_enable = 4'hF;
        #1;
        chk("t3_wr_forward", mem_write_req, 1);
        chk("t3_wr_ready", m1_ready, 1);
        chk("t3_wr_data", mem_write_data, 32'h55);
        chk("t3_wr_be", mem_byte_enable, 4'hF);
        cyc();
        m1_write_req = 0; m1_read_req = 1;
        mem_read_data_valid = 1; mem_read_data = 32'h1111;
        #1;
        chk("t3_pop_stall", m1_ready, 0);
        chk("t3_pop_valid", m1_read_data_valid, 1);
        chk("t3_pop_data", m1_read_data, 32'h1111);
        cyc();
        mem_read_data_valid = 0;
        #1 chk("t3_unblock", m1_ready, 1);
        cyc();
        m1_read_req = 0;

        // 4: full FIFO, return and new m0 read in the same cycle.
        m0_read_req = 1; m0_addr = 32'h3000;
        mem_read_data_valid = 1; mem_read_data = 32'h2222;
        #1;
        chk("t4_m0_stalled", m0_ready, 0);
        chk("t4_m1_valid", m1_read_data_valid, 1);
        cyc();
        mem_read_data_valid = 0;
        #1 chk("t4_m0_accept", m0_ready, 1);
        cyc();
        m0_read_req = 0;
        for (int k = 0; k < 4; k++) begin
            mem_read_data_valid = 1; mem_read_data = 32'h3000_0000 + 32'(k);
            #1;
            if (k < 3) chk("t4_drain_m1", m1_read_data_valid, 1);
            else chk("t4_drain_m0", m0_read_data_valid, 1);
            cyc();
        end
        #1;
        chk("t4_empty_m0", m0_read_data_valid, 0);
        chk("t4_empty_m1", m1_read_data_valid, 0);
        cyc();
        idle();

        // 5: mem_ready low for three cycles with both requesting.
        do_reset();
        m0_read_req = 1; m1_read_req = 1; mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_m0_ready_low", m0_ready, 0);
            chk("t5_m1_ready_low", m1_ready, 0);
            cyc();
        end
        mem_ready = 1;
        #1 chk("t5_first_m0", m0_ready, 1);
        cyc();
        #1 chk("t5_second_m1", m1_ready, FIXED ? 0 : 1);
        cyc();
        #1 chk("t5_third_m0", m0_ready, 1);
        cyc();
        idle();

        // 6: reset with two reads in flight; stale returns are dropped.
        do_reset();
        m0_read_req = 1;
        cyc();
        m0_read_req = 0; m1_read_req = 1;
        cyc();
        m1_read_req = 0;
        reset_n = 0;
        cyc();
        reset_n = 1;
        for (int k = 0; k < 2; k++) begin
            mem_read_data_valid = 1; mem_read_data = 32'h6000 + 32'(k);
            #1;
            chk("t6_stale_m0", m0_read_data_valid, 0);
            chk("t6_stale_m1", m1_read_data_valid, 0);
            cyc();
        end
        mem_read_data_valid = 0;
        m1_read_req = 1; m1_addr = 32'h4000;
        #1 chk("t6_new_ready", m1_ready, 1);
        cyc();
        m1_read_req = 0;
        mem_read_data_valid = 1; mem_read_data = 32'h7777;
        #1;
        chk("t6_new_valid", m1_read_data_valid, 1);
        chk("t6_new_data", m1_read_data, 32'h7777);
        chk("t6_new_m0", m0_read_data_valid, 0);
        cyc();
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
